// File: rtl/i2c_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_pkg : shared widths, ACK levels and FSM state encoding for the I2C target
// Revision: 1.0
// ----------------------------------------------------------------------------
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
  localparam logic [2:0] ST_WRITE     = 3'd3;
  localparam logic [2:0] ST_WRITE_ACK = 3'd4;
  localparam logic [2:0] ST_READ      = 3'd5;
  localparam logic [2:0] ST_READ_ACK  = 3'd6;
  localparam logic [2:0] ST_IGNORE    = 3'd7;

endpackage
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_sync_edge : pin synchronizer plus history flop, giving level/rise/fall
// Revision: 1.0
// ----------------------------------------------------------------------------
module i2c_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // Reset to the idle bus level so releasing reset never fakes an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_hist <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = level & ~r_hist;
  assign fall  = ~level & r_hist;

endmodule
`default_nettype wire

// File: rtl/i2c_target_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_target_ctrl : I2C target frame controller (START/STOP, addr, data, ACK)
// Revision: 1.0
// ----------------------------------------------------------------------------
module i2c_target_ctrl
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TGT_ADDR    = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic                  busy,
  output logic                  addr_hit,
  output logic                  rw,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic                  tx_req
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_addr_match;

  logic [2:0]            r_state;
  logic [2:0]            r_bit_cnt;
  logic                  r_byte_done;
  logic [I2C_BYTE_W-1:0] r_shift;
  logic [I2C_BYTE_W-1:0] r_tx_shift;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_scl_sync (
    .clk(clk), .reset(reset), .din(scl_in),
    .level(w_scl), .rise(w_scl_rise), .fall(w_scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sda_sync (
    .clk(clk), .reset(reset), .din(sda_in),
    .level(w_sda), .rise(w_sda_rise), .fall(w_sda_fall)
  );

  // SCL must be high in both samples; a simultaneous SCL change is an edge only.
  assign w_start      = w_scl & ~w_scl_rise & w_sda_fall;
  assign w_stop       = w_scl & ~w_scl_rise & w_sda_rise;
  assign w_addr_match = (r_shift[I2C_BYTE_W-1:1] == TGT_ADDR) && (TGT_ADDR != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_byte_done <= 1'b0;
      r_shift     <= '0;
      r_tx_shift  <= '0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      addr_hit    <= 1'b0;
      rw          <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_req      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (w_stop) begin
        r_state     <= ST_IDLE;
        r_bit_cnt   <= 3'd0;
        r_byte_done <= 1'b0;
        sda_oe      <= 1'b0;
        busy        <= 1'b0;
        addr_hit    <= 1'b0;
      end else if (w_start) begin
        r_state     <= ST_ADDR;
        r_bit_cnt   <= 3'd0;
        r_byte_done <= 1'b0;
        sda_oe      <= 1'b0;
        busy        <= 1'b0 | 1'b1;
        addr_hit    <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR: begin
            if (w_scl_rise && !r_byte_done) begin
              r_shift   <= {r_shift[I2C_BYTE_W-2:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                rw          <= w_sda;
                r_byte_done <= 1'b1;
              end
            end else if (w_scl_fall && r_byte_done) begin
              r_byte_done <= 1'b0;
              if (w_addr_match) begin
                r_state <= ST_ADDR_ACK;
                sda_oe  <= 1'b1;
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              addr_hit <= 1'b1;
              if (rw) begin
                r_state    <= ST_READ;
                tx_req     <= 1'b1;
                r_tx_shift <= tx_data;
                sda_oe     <= ~tx_data[I2C_BYTE_W-1];
              end else begin
                r_state <= ST_WRITE;
                sda_oe  <= 1'b0;
              end
            end
          end
          ST_WRITE: begin
            if (w_scl_rise && !r_byte_done) begin
              r_shift   <= {r_shift[I2C_BYTE_W-2:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                rx_data     <= {r_shift[I2C_BYTE_W-2:0], w_sda};
                rx_valid    <= 1'b1;
                r_byte_done <= 1'b1;
              end
            end else if (w_scl_fall && r_byte_done) begin
              r_byte_done <= 1'b0;
              r_state     <= ST_WRITE_ACK;
              sda_oe      <= 1'b1;
            end
          end
          ST_WRITE_ACK: begin
            if (w_scl_fall) begin
              r_state <= ST_WRITE;
              sda_oe  <= 1'b0;
            end
          end
          ST_READ: begin
            if (w_scl_rise && !r_byte_done) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_byte_done <= 1'b1;
            end else if (w_scl_fall) begin
              if (r_byte_done) begin
                r_byte_done <= 1'b0;
                r_state     <= ST_READ_ACK;
                sda_oe      <= 1'b0;
              end else begin
                r_tx_shift <= {r_tx_shift[I2C_BYTE_W-2:0], 1'b0};
                sda_oe     <= ~r_tx_shift[I2C_BYTE_W-2];
              end
            end
          end
          ST_READ_ACK: begin
            if (w_scl_rise && !r_byte_done) begin
              if (w_sda == NACK) begin
                r_state <= ST_IGNORE;
                sda_oe  <= 1'b0;
              end else begin
                r_byte_done <= 1'b1;
              end
            end else if (w_scl_fall && r_byte_done) begin
              r_byte_done <= 1'b0;
              r_state     <= ST_READ;
              tx_req      <= 1'b1;
              r_tx_shift  <= tx_data;
              sda_oe      <= ~tx_data[I2C_BYTE_W-1];
            end
          end
          ST_IGNORE: sda_oe <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_i2c_target_ctrl : bus-master bench with queued expectations for ACKs,
// received write bytes and read bytes.  Revision: 1.0
// ----------------------------------------------------------------------------
module tb_i2c_target_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe, busy, addr_hit, rw, rx_valid, tx_req;
  logic [7:0] rx_data, tx_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n_rx     = 0;
  int n_txreq  = 0;
  bit oe_seen  = 1'b0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];
  logic       exp_ack[$];

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_ctrl dut (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_line),
    .sda_oe(sda_oe), .busy(busy), .addr_hit(addr_hit), .rw(rw),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (sda_oe) oe_seen = 1'b1;
      if (rx_valid) begin
        n_rx++;
        check_eq("rx_hit", addr_hit, 1);
        check_eq("rx_pending", exp_rx.size() > 0, 1);
        if (exp_rx.size() > 0) check_eq("rx_data", rx_data, exp_rx.pop_front());
      end
      if (tx_req) begin
        n_txreq++;
        check_eq("txreq_hit", addr_hit, 1);
        check_eq("txreq_excl", rx_valid, 0);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic q_wait();
    repeat (8) @(negedge clk);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; q_wait();
    scl = 1'b1; q_wait();
    scl = 1'b0; q_wait();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; q_wait();
    scl = 1'b1;
    repeat (4) @(negedge clk);
    b = sda_line;
    repeat (4) @(negedge clk);
    scl = 1'b0; q_wait();
  endtask

  task automatic do_start();
    sda_m = 1'b1; scl = 1'b1; q_wait();
    sda_m = 1'b0; q_wait();
    scl = 1'b0; q_wait();
  endtask

  task automatic do_rstart();
    sda_m = 1'b1; q_wait();
    scl = 1'b1; q_wait();
    sda_m = 1'b0; q_wait();
    scl = 1'b0; q_wait();
  endtask

  task automatic do_stop();
    sda_m = 1'b0; q_wait();
    scl = 1'b1; q_wait();
    sda_m = 1'b1; q_wait();
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b, input logic ack_exp);
    logic a;
    exp_ack.push_back(ack_exp);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(a);
    check_eq(tag, a, exp_ack.pop_front());
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp, input logic [7:0] next_tx,
                           input logic m_ack);
    logic [7:0] got;
    logic       b;
    exp_rd.push_back(exp);
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      got[i] = b;
    end
    check_eq(tag, got, exp_rd.pop_front());
    tx_data = next_tx;
    write_bit(m_ack);
  endtask

  initial begin
    int rx0, tx0, k;
    reset = 1'b0; scl = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
    repeat (5) @(negedge clk);
    check_eq("rst_sda_oe", sda_oe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_addr_hit", addr_hit, 0);
    check_eq("rst_rw", rw, 0);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_tx_req", tx_req, 0);
    check_eq("rst_rx_data", rx_data, 0);
    reset = 1'b1;
    q_wait();

    // 1: write two bytes
    rx0 = n_rx;
    do_start();
    check_eq("t1_busy", busy, 1);
    send_byte("t1_addr_ack", 8'hA0, 1'b0);
    check_eq("t1_addr_hit", addr_hit, 1);
    check_eq("t1_rw", rw, 0);
    exp_rx.push_back(8'hA5);
    send_byte("t1_d0_ack", 8'hA5, 1'b0);
    exp_rx.push_back(8'h3C);
    send_byte("t1_d1_ack", 8'h3C, 1'b0);
    do_stop();
    check_eq("t1_busy_end", busy, 0);
    check_eq("t1_hit_end", addr_hit, 0);
    check_eq("t1_rx_count", n_rx - rx0, 2);

    // 2: read two bytes, ACK then NACK
    tx0 = n_txreq;
    tx_data = 8'h96;
    do_start();
    send_byte("t2_addr_ack", 8'hA1, 1'b0);
    check_eq("t2_rw", rw, 1);
    recv_byte("t2_rd0", 8'h96, 8'h01, 1'b0);
    recv_byte("t2_rd1", 8'h01, 8'h00, 1'b1);
    q_wait();
    check_eq("t2_oe_released", sda_oe, 0);
    check_eq("t2_txreq_count", n_txreq - tx0, 2);
    check_eq("t2_busy", busy, 1);
    do_stop();
    check_eq("t2_busy_end", busy, 0);

    // 3: other address is ignored
    rx0 = n_rx; oe_seen = 1'b0;
    do_start();
    send_byte("t3_addr_nack", 8'hA2, 1'b1);
    send_byte("t3_data_nack", 8'h11, 1'b1);
    check_eq("t3_oe_never", oe_seen, 0);
    check_eq("t3_addr_hit", addr_hit, 0);
    check_eq("t3_busy", busy, 1);
    do_stop();
    check_eq("t3_busy_end", busy, 0);
    check_eq("t3_rx_count", n_rx - rx0, 0);

    // 4: repeated START mid-byte, then read
    rx0 = n_rx;
    do_start();
    send_byte("t4_addr_ack", 8'hA0, 1'b0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    tx_data = 8'h5A;
    do_rstart();
    check_eq("t4_hit_cleared", addr_hit, 0);
    send_byte("t4_raddr_ack", 8'hA1, 1'b0);
    check_eq("t4_rw", rw, 1);
    check_eq("t4_addr_hit", addr_hit, 1);
    recv_byte("t4_rd", 8'h5A, 8'h00, 1'b1);
    do_stop();
    check_eq("t4_rx_count", n_rx - rx0, 0);

    // 5: asynchronous reset while ACKing the address
    do_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b0 : (8'hA0 >> i) & 1'b1);
    k = 0;
    while (!sda_oe && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("t5_oe_seen", sda_oe, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("t5_async_oe", sda_oe, 0);
    check_eq("t5_async_busy", busy, 0);
    check_eq("t5_async_hit", addr_hit, 0);
    scl = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    q_wait();
    do_start();
    check_eq("t5_restart_busy", busy, 1);
    send_byte("t5_addr_ack", 8'hA0, 1'b0);
    do_stop();

    // 6: simultaneous SCL/SDA changes are SCL edges only
    sda_m = 1'b1; scl = 1'b1; q_wait();
    scl = 1'b0; sda_m = 1'b0; q_wait();
    check_eq("t6_no_start", busy, 0);
    scl = 1'b1; sda_m = 1'b1; q_wait();
    do_start();
    send_byte("t6_addr_ack", 8'hA0, 1'b0);
    exp_rx.push_back(8'hC3);
    sda_m = 1'b0; q_wait();
    scl = 1'b1; sda_m = 1'b1; q_wait();
    check_eq("t6_no_stop", busy, 1);
    scl = 1'b0; q_wait();
    scl = 1'b1; q_wait();
    scl = 1'b0; sda_m = 1'b0; q_wait();
    check_eq("t6_no_rstart", addr_hit, 1);
    write_bit(1'b0); write_bit(1'b0); write_bit(1'b0); write_bit(1'b0);
    write_bit(1'b1); write_bit(1'b1);
    begin
      logic a;
      read_bit(a);
      check_eq("t6_data_ack", a, 0);
    end
    do_stop();
    check_eq("t6_rx_left", exp_rx.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
